// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared widths and entry types for the element scheduler
package sched_pkg;
   localparam int TW = 32;
   localparam int CW = 64;

   typedef logic [TW-1:0] sched_time_t;

   typedef struct packed {
      sched_time_t     ts;
      logic [CW-1:0]   cmd;
   } sched_entry_t;
endpackage

// File: rtl/element_sched_if.sv
// rtl/element_sched_if.sv - host push channel and element command channel
interface element_sched_if #(
   parameter int tw = 32,
   parameter int cw = 64
);
   logic          push;
   logic [tw-1:0] push_time;
   logic [cw-1:0] push_cmd;
   logic [cw-1:0] command;
   logic          cstrobe;

   modport master (output push, push_time, push_cmd, input command, cstrobe);
   modport slave  (input push, push_time, push_cmd, output command, cstrobe);
endinterface

// File: rtl/sched_fifo.sv
// rtl/sched_fifo.sv - synchronous FIFO of scheduler entries; head valid the cycle after a write
module sched_fifo
   import sched_pkg::*;
#(
   parameter int  depth   = 16,
   parameter type entry_t = sched_entry_t
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  entry_t                   wdata,
   input  logic                     pop,
   output entry_t                   head,
   output logic [$clog2(depth):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int aw = $clog2(depth);
   localparam logic [aw:0] depth_l = (aw+1)'(depth);

   entry_t          mem [depth];
   logic [aw-1:0]   wr_ptr;
   logic [aw-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   // Acceptance is judged on start-of-cycle occupancy: a pop never frees a slot for the same-cycle push.
   assign full    = (level == depth_l);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + aw'(1);
         if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (aw+1)'(1);
            2'b01:   level <= level - (aw+1)'(1);
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/element_sched.sv
// rtl/element_sched.sv - timed command scheduler for one waveform element
// Optional: SCHED_LATE_ISSUE_EN issues late heads instead of discarding them.
module element_sched
   import sched_pkg::*;
#(
   parameter int depth = 16,
   parameter int tw    = TW,
   parameter int cw    = CW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     trun,
   input  logic                     tclear,
   input  logic                     clr_flags,
   element_sched_if.slave           bus,
   output logic [tw-1:0]            tnow,
   output logic [$clog2(depth):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic                     late,
   output logic                     overflow
);
   typedef struct packed {
      logic [tw-1:0] ts;
      logic [cw-1:0] cmd;
   } entry_t;

   entry_t        wdata;
   entry_t        head;
   logic [tw-1:0] d;
   logic          evaluate;
   logic          hit;
   logic          past;
   logic          pop;
   logic          issue;
   logic [cw-1:0] command_q;
   logic          cstrobe_q;

   assign wdata = '{ts: bus.push_time, cmd: bus.push_cmd};

   sched_fifo #(.depth(depth), .entry_t(entry_t)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.push),
      .wdata (wdata),
      .pop   (pop),
      .head  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // Modular difference: a set MSB means the head time is already behind the timeline.
   assign d        = head.ts - tnow;
   assign evaluate = trun && !empty;
   assign hit      = evaluate && (d == '0);
   assign past     = evaluate && d[tw-1];
   assign pop      = hit || past;
`ifdef SCHED_LATE_ISSUE_EN
   assign issue    = hit || past;
`else
   assign issue    = hit;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         tnow      <= '0;
         command_q <= '0;
         cstrobe_q <= 1'b0;
         late      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (tclear)    tnow <= '0;
         else if (trun) tnow <= tnow + tw'(1);
         cstrobe_q <= issue;
         if (issue) command_q <= head.cmd;
         late     <= (late && !clr_flags) || past;
         overflow <= (overflow && !clr_flags) || (bus.push && full);
      end
   end

   assign bus.command = command_q;
   assign bus.cstrobe = cstrobe_q;
endmodule

// File: tb/tb_element_sched.sv
// tb/tb_element_sched.sv - scoreboard bench for element_sched (32-bit and 8-bit timer builds)
module tb_element_sched;
   typedef struct packed {
      logic [63:0] cmd;
      logic [31:0] t;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, trun, tclear, clr_flags;
   logic [31:0] tnow;
   logic [4:0]  level;
   logic        full, empty, late, overflow;

   logic        trun8, tclear8, clr8;
   logic [7:0]  tnow8;
   logic [4:0]  level8;
   logic        full8, empty8, late8, ovf8;

   int errors = 0;
   int checks = 0;
   int nstrobe = 0;
   exp_t sb[$];
   exp_t sb8[$];

   element_sched_if #(.tw(32), .cw(64)) bus ();
   element_sched_if #(.tw(8),  .cw(64)) bus8 ();

   element_sched #(.depth(16), .tw(32), .cw(64)) dut (
      .clk(clk), .reset(reset), .trun(trun), .tclear(tclear), .clr_flags(clr_flags),
      .bus(bus), .tnow(tnow), .level(level), .full(full), .empty(empty),
      .late(late), .overflow(overflow)
   );

   element_sched #(.depth(16), .tw(8), .cw(64)) dut8 (
      .clk(clk), .reset(reset), .trun(trun8), .tclear(tclear8), .clr_flags(clr8),
      .bus(bus8), .tnow(tnow8), .level(level8), .full(full8), .empty(empty8),
      .late(late8), .overflow(ovf8)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.cstrobe) begin
         exp_t e;
         nstrobe++;
         if (sb.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            chk("command", bus.command, e.cmd);
            chk("issue_tnow", {32'd0, tnow}, {32'd0, e.t});
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && bus8.cstrobe) begin
         exp_t e;
         if (sb8.size() == 0) chk("unexpected_strobe8", 64'd1, 64'd0);
         else begin
            e = sb8.pop_front();
            chk("command8", bus8.command, e.cmd);
            chk("issue_tnow8", {56'd0, tnow8}, {32'd0, e.t});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_t(input logic [31:0] target);
      int n = 0;
      while (tnow != target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (tnow != target) chk("timeout_tnow", {32'd0, tnow}, {32'd0, target});
   endtask

   task automatic wait_t8(input logic [7:0] target);
      int n = 0;
      while (tnow8 != target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (tnow8 != target) chk("timeout_tnow8", {56'd0, tnow8}, {56'd0, target});
   endtask

   // One-cycle push; when expect_issue is set the scoreboard awaits a strobe at issue_at.
   task automatic push1(input logic [31:0] t, input logic [63:0] c,
                        input bit expect_issue, input logic [31:0] issue_at);
      bus.push      = 1'b1;
      bus.push_time = t;
      bus.push_cmd  = c;
      if (expect_issue) sb.push_back('{cmd: c, t: issue_at});
      @(negedge clk);
      bus.push = 1'b0;
   endtask

   initial begin
      logic [31:0] b;
      int          s0;
      reset = 1'b1; trun = 1'b0; tclear = 1'b0; clr_flags = 1'b0;
      trun8 = 1'b0; tclear8 = 1'b0; clr8 = 1'b0;
      bus.push = 1'b0; bus.push_time = '0; bus.push_cmd = '0;
      bus8.push = 1'b0; bus8.push_time = '0; bus8.push_cmd = '0;
      tick(2);
      chk("rst_tnow", {32'd0, tnow}, 64'd0);
      chk("rst_level", {59'd0, level}, 64'd0);
      chk("rst_empty", {63'd0, empty}, 64'd1);
      chk("rst_full", {63'd0, full}, 64'd0);
      chk("rst_command", bus.command, 64'd0);
      chk("rst_cstrobe", {63'd0, bus.cstrobe}, 64'd0);
      chk("rst_late", {63'd0, late}, 64'd0);
      chk("rst_overflow", {63'd0, overflow}, 64'd0);
      reset = 1'b0;
      trun  = 1'b1;

      // single on-time command
      wait_t(5);
      push1(20, 64'hA5, 1'b1, 21);
      wait_t(25);
      chk("t1_strobes", nstrobe, 1);
      chk("t1_level", {59'd0, level}, 64'd0);
      chk("t1_late", {63'd0, late}, 64'd0);

      // back-to-back pushes drain in order
      wait_t(26);
      push1(30, 64'h1030, 1'b1, 31);
      push1(40, 64'h1040, 1'b1, 41);
      push1(50, 64'h1050, 1'b1, 51);
      chk("t2_level3", {59'd0, level}, 64'd3);
      wait_t(32);
      chk("t2_level2", {59'd0, level}, 64'd2);
      wait_t(42);
      chk("t2_level1", {59'd0, level}, 64'd1);
      wait_t(52);
      chk("t2_level0", {59'd0, level}, 64'd0);
      chk("t2_late", {63'd0, late}, 64'd0);

      // late command after a timer clear
      tclear = 1'b1;
      tick(1);
      tclear = 1'b0;
      chk("t3_clear", {32'd0, tnow}, 64'd0);
      wait_t(10);
`ifdef SCHED_LATE_ISSUE_EN
      push1(3, 64'h33, 1'b1, 12);
`else
      push1(3, 64'h33, 1'b0, 0);
`endif
      wait_t(13);
      chk("t3_late", {63'd0, late}, 64'd1);
      chk("t3_empty", {63'd0, empty}, 64'd1);
      clr_flags = 1'b1;
      tick(1);
      clr_flags = 1'b0;
      chk("t3_late_clr", {63'd0, late}, 64'd0);

      // fill to full with the timer stopped, 17th push overflows
      trun = 1'b0;
      b = tnow;
      for (int i = 0; i < 17; i++)
         push1(b + 100 + i, 64'h200 + i, i < 16, b + 101 + i);
      chk("t4_full", {63'd0, full}, 64'd1);
      chk("t4_level", {59'd0, level}, 64'd16);
      chk("t4_overflow", {63'd0, overflow}, 64'd1);
      clr_flags = 1'b1;
      tick(1);
      clr_flags = 1'b0;
      chk("t4_ovf_clr", {63'd0, overflow}, 64'd0);
      trun = 1'b1;
      wait_t(b + 125);
      chk("t4_drained", {63'd0, empty}, 64'd1);
      chk("t4_late", {63'd0, late}, 64'd0);

      // head time == tnow while frozen: no issue until trun returns
      trun = 1'b0;
      b = tnow;
      s0 = nstrobe;
      push1(b, 64'h66, 1'b1, b + 1);
      tick(3);
      chk("t6_frozen_strobes", nstrobe, s0);
      chk("t6_frozen_level", {59'd0, level}, 64'd1);
      trun = 1'b1;
      tick(2);
      chk("t6_level", {59'd0, level}, 64'd0);
      chk("t6_strobes", nstrobe, s0 + 1);
      chk("t6_late", {63'd0, late}, 64'd0);

      // reset with entries queued discards them
      b = tnow;
      push1(b + 10, 64'h71, 1'b0, 0);
      push1(b + 11, 64'h72, 1'b0, 0);
      push1(b + 12, 64'h73, 1'b0, 0);
      chk("t7_level3", {59'd0, level}, 64'd3);
      s0 = nstrobe;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t7_rst_level", {59'd0, level}, 64'd0);
      tick(1);
      chk("t7_cstrobe", {63'd0, bus.cstrobe}, 64'd0);
      chk("t7_tnow", {32'd0, tnow}, 64'd1);
      tick(30);
      chk("t7_no_strobes", nstrobe, s0);

      // 8-bit timer wraps: push time 4 at tnow 250 is in the future
      trun8 = 1'b1;
      wait_t8(250);
      bus8.push      = 1'b1;
      bus8.push_time = 8'd4;
      bus8.push_cmd  = 64'hBEEF;
      sb8.push_back('{cmd: 64'hBEEF, t: 32'd5});
      tick(1);
      bus8.push = 1'b0;
      wait_t8(10);
      chk("t5_late8", {63'd0, late8}, 64'd0);
      chk("t5_level8", {59'd0, level8}, 64'd0);

      chk("sb_drain", sb.size(), 0);
      chk("sb8_drain", sb8.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
